ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
Sits between ps2_rx and the VGA drawing logic. Consumes completed PS/2 scan codes and decodes make/break (F0) and extended (E0) prefixes into per-direction held-key flags. Once per video frame it moves a sprite position by STEP per held direction, clamped to the visible area. The VGA stage uses x_pos/y_pos directly as the sprite origin, so ps2_rx no longer needs to be reset after each key.

Parameters:
STEP, 4, pixels moved per frame per held direction
SPRITE_SIZE, 50, sprite edge length in pixels; used for clamping
WIDTH, 640, visible width in pixels
HEIGHT, 480, visible height in pixels
INIT_X, 0, x_pos reset value
INIT_Y, 0, y_pos reset value

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-low reset
rx_done_tick  input  1  one-clk pulse: rx_data holds a complete scan code
rx_data  input  8  received scan code byte
screen_end  input  1  frame-boundary flag from the timing generator; may stay high for several clk cycles
key_held  output  4  {right, left, down, up} held flags
x_pos  output  10  sprite left edge
y_pos  output  10  sprite top edge
event_valid  output  1  one-clk pulse on every decoded key make/break
event_code  output  8  final scan-code byte of the event (prefixes stripped)
event_ext  output  1  event carried the E0 prefix
event_break  output  1  event was a release

Behaviour:
- Reset (reset=0, asynchronous) values: FSM in IDLE; key_held=0; x_pos=INIT_X; y_pos=INIT_Y; event_valid=0, event_code=0, event_ext=0, event_break=0; screen_end edge-detect register=0.
- The block acts only on cycles where rx_done_tick=1. It ignores rx_data at all other times.
- Decoder FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: F0 goes to BRK; E0 goes to EXT; any other byte is a make event, return to IDLE.
  - BRK: E0 is ignored (stay in BRK); F0 stays in BRK; any other byte is a break event, go to IDLE.
  - EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is an extended make event, go to IDLE.
  - EXT_BRK: F0/E0 stay in EXT_BRK; any other byte is an extended break event, go to IDLE.
- Event output: event_valid pulses for exactly one clk, on the cycle after the terminating rx_done_tick. event_code, event_ext and event_break are registered on that same edge and hold until the next event.
- Direction map. Non-extended: 1D=up, 1B=down, 1C=left, 23=right. Extended: 75=up, 72=down, 6B=left, 74=right.
  - A make event sets the mapped bit; a break event clears it.
  - Unmapped codes change no key_held bit but still produce an event.
  - key_held updates on the same edge as event_valid.
  - Typematic repeats (repeated makes) are idempotent.
- Frame update fires once per rising edge of screen_end (screen_end=1 and registered previous value=0), on the following clk edge.
  - dx = +STEP if right held, -STEP if left held; both held or neither gives 0. dy works the same way with down/up.
  - Clamping uses 11-bit signed intermediates. x range is 0..WIDTH-SPRITE_SIZE (590); y range is 0..HEIGHT-SPRITE_SIZE (430). Results below 0 saturate to 0; results above the maximum saturate to the maximum. No wrap-around.
- If a frame update and an event land on the same edge, the update uses key_held as it was before that edge; the new key state applies from the next frame.
- Reset asserted mid-sequence (e.g. after E0) discards the partial prefix. A byte after reset release is decoded from IDLE.

Test Plan:
- Reset with INIT_X=100, INIT_Y=200, then release -> x_pos=100, y_pos=200, key_held=0, event_valid=0.
- Bytes 1D, then three screen_end rising edges, each held high 4 clks -> key_held=0001, y_pos decreases by exactly 4 per frame (196, 192, 188). Then F0 1D -> event_break=1, key_held=0000, y_pos frozen.
- Extended sequence E0 74 then E0 F0 74 -> two events with event_ext=1, event_code=74, event_break 0 then 1. key_held bit3 set then cleared; x_pos increases by 4 only on frames in between.
- Clamp: x_pos=588 with right held, one frame -> 590; next frame stays 590. y_pos=2 with up held, one frame -> 0.
- Opposing keys: 1C and 23 both held across two frames -> x_pos unchanged; key_held=1100.
- Reset pulsed low between E0 and 75, then 75 sent alone -> non-extended make event (event_ext=0, code 75), key_held unchanged.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// Scan-code input and decoded-event output bundle between ps2_rx, the key
// tracker and whatever consumes key events.
interface ps2_key_tracker_if;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_ext;
  logic       event_break;

  // Master supplies scan codes and observes events; slave is the tracker.
  modport master (
    output rx_done_tick, rx_data,
    input  event_valid, event_code, event_ext, event_break
  );
  modport slave (
    input  rx_done_tick, rx_data,
    output event_valid, event_code, event_ext, event_break
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 make/break (F0) and extended (E0) prefixes into held-direction
// flags and moves a clamped sprite origin once per video frame.
module ps2_key_tracker #(
  parameter int STEP        = 4,
  parameter int SPRITE_SIZE = 50,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int INIT_X      = 0,
  parameter int INIT_Y      = 0
) (
  input  logic                clk,
  input  logic                reset,
  ps2_key_tracker_if.slave    bus,
  input  logic                screen_end,
  output logic [3:0]          key_held,
  output logic [9:0]          x_pos,
  output logic [9:0]          y_pos
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic signed [10:0] X_MAX  = 11'(WIDTH - SPRITE_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(HEIGHT - SPRITE_SIZE);

  logic [1:0] state, state_nxt;
  logic       term, term_ext, term_brk;
  logic       is_f0, is_e0;
  logic       screen_end_q;
  logic       frame_tick;
  logic [3:0] mask;
  logic [9:0] x_nxt, y_nxt;

  // key_held bit order: {right, left, down, up}
  function automatic logic [3:0] dir_mask(input logic ext, input logic [7:0] code);
    dir_mask = 4'b0000;
    if (!ext) begin
      case (code)
        8'h1D:   dir_mask = 4'b0001;
        8'h1B:   dir_mask = 4'b0010;
        8'h1C:   dir_mask = 4'b0100;
        8'h23:   dir_mask = 4'b1000;
        default: dir_mask = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h75:   dir_mask = 4'b0001;
        8'h72:   dir_mask = 4'b0010;
        8'h6B:   dir_mask = 4'b0100;
        8'h74:   dir_mask = 4'b1000;
        default: dir_mask = 4'b0000;
      endcase
    end
  endfunction

  // Signed 11-bit intermediate so a step below zero saturates instead of wrapping.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic signed [10:0] max_s);
    logic signed [10:0] sum;
    sum = signed'({1'b0, pos});
    if (inc && !dec)      sum = sum + STEP_S;
    else if (dec && !inc) sum = sum - STEP_S;
    if (sum < 0)          step_axis = 10'd0;
    else if (sum > max_s) step_axis = max_s[9:0];
    else                  step_axis = sum[9:0];
  endfunction

  assign is_f0      = (bus.rx_data == 8'hF0);
  assign is_e0      = (bus.rx_data == 8'hE0);
  assign frame_tick = screen_end && !screen_end_q;
  assign mask       = dir_mask(term_ext, bus.rx_data);
  assign x_nxt      = step_axis(x_pos, key_held[3], key_held[2], X_MAX);
  assign y_nxt      = step_axis(y_pos, key_held[1], key_held[0], Y_MAX);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    state_nxt = state;
    term      = 1'b0;
    term_ext  = 1'b0;
    term_brk  = 1'b0;
    if (bus.rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (is_f0)      state_nxt = ST_BRK;
          else if (is_e0) state_nxt = ST_EXT;
          else            term      = 1'b1;
        end
        ST_BRK: begin
          if (!is_f0 && !is_e0) begin
            term      = 1'b1;
            term_brk  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (is_f0) begin
            state_nxt = ST_EXT_BRK;
          end else if (!is_e0) begin
            term      = 1'b1;
            term_ext  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          if (!is_f0 && !is_e0) begin
            term      = 1'b1;
            term_ext  = 1'b1;
            term_brk  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      key_held        <= 4'b0000;
      x_pos           <= 10'(INIT_X);
      y_pos           <= 10'(INIT_Y);
      screen_end_q    <= 1'b0;
      bus.event_valid <= 1'b0;
      bus.event_code  <= 8'h00;
      bus.event_ext   <= 1'b0;
      bus.event_break <= 1'b0;
    end else begin
      state           <= state_nxt;
      screen_end_q    <= screen_end;
      bus.event_valid <= term;
      if (term) begin
        bus.event_code  <= bus.rx_data;
        bus.event_ext   <= term_ext;
        bus.event_break <= term_brk;
        key_held        <= term_brk ? (key_held & ~mask) : (key_held | mask);
      end
      // Frame step reads key_held before this edge's event lands.
      if (frame_tick) begin
        x_pos <= x_nxt;
        y_pos <= y_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench: event scoreboard with a decoupled monitor, plus direct checks
// of key_held and sprite position after each frame.
module tb_ps2_key_tracker;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       screen_end = 1'b0;
  logic [3:0] key_held, key_held_c;
  logic [9:0] x_pos, y_pos, x_pos_c, y_pos_c;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];

  ps2_key_tracker_if bus ();
  ps2_key_tracker_if bus_c ();

  ps2_key_tracker #(.INIT_X(100), .INIT_Y(200)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .screen_end (screen_end),
    .key_held   (key_held),
    .x_pos      (x_pos),
    .y_pos      (y_pos)
  );

  // Second instance starts near the corner to exercise clamping.
  ps2_key_tracker #(.INIT_X(588), .INIT_Y(2)) dut_c (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_c),
    .screen_end (screen_end),
    .key_held   (key_held_c),
    .x_pos      (x_pos_c),
    .y_pos      (y_pos_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back('{code: code, ext: ext, brk: brk});
  endtask

  task automatic send(input logic [7:0] b, input bit to_c = 1'b0);
    @(posedge clk); #1;
    if (to_c) begin
      bus_c.rx_data      = b;
      bus_c.rx_done_tick = 1'b1;
    end else begin
      bus.rx_data      = b;
      bus.rx_done_tick = 1'b1;
    end
    @(posedge clk); #1;
    bus.rx_done_tick   = 1'b0;
    bus_c.rx_done_tick = 1'b0;
    // Idle-time garbage must be ignored while the tick is low.
    bus.rx_data        = 8'hF0;
    bus_c.rx_data      = 8'hE0;
  endtask

  task automatic frame();
    @(posedge clk); #1 screen_end = 1'b1;
    repeat (4) @(posedge clk);
    #1 screen_end = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  // Scan-code byte and screen_end rising edge sampled on the same clock edge.
  task automatic send_with_frame(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    screen_end       = 1'b1;
    @(posedge clk); #1;
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'hF0;
    repeat (3) @(posedge clk);
    #1 screen_end = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_pos(input string tag, input logic [9:0] ex, input logic [9:0] ey);
    @(negedge clk);
    check({tag, "_x"}, 32'(x_pos), 32'(ex));
    check({tag, "_y"}, 32'(y_pos), 32'(ey));
  endtask

  // Monitor: every event pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (reset && bus.event_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0h ext %0b brk %0b, none expected",
                 bus.event_code, bus.event_ext, bus.event_break);
      end else begin
        e = exp_q.pop_front();
        check("ev_code", 32'(bus.event_code), 32'(e.code));
        check("ev_ext", 32'(bus.event_ext), 32'(e.ext));
        check("ev_break", 32'(bus.event_break), 32'(e.brk));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.rx_done_tick   = 1'b0;
    bus.rx_data        = 8'h00;
    bus_c.rx_done_tick = 1'b0;
    bus_c.rx_data      = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_x", 32'(x_pos), 32'd100);
    check("rst_y", 32'(y_pos), 32'd200);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_event_valid", 32'(bus.event_valid), 32'd0);
    check("rst_event_code", 32'(bus.event_code), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_x", 32'(x_pos), 32'd100);
    check("post_rst_y", 32'(y_pos), 32'd200);

    // Up held with a typematic repeat, three frames.
    expect_ev(8'h1D, 1'b0, 1'b0); send(8'h1D);
    expect_ev(8'h1D, 1'b0, 1'b0); send(8'h1D);
    @(negedge clk); check("up_held", 32'(key_held), 32'b0001);
    frame(); check_pos("up_f1", 10'd100, 10'd196);
    frame(); check_pos("up_f2", 10'd100, 10'd192);
    frame(); check_pos("up_f3", 10'd100, 10'd188);
    expect_ev(8'h1D, 1'b0, 1'b1); send(8'hF0); send(8'h1D);
    @(negedge clk); check("up_released", 32'(key_held), 32'b0000);
    frame(); check_pos("up_frozen", 10'd100, 10'd188);

    // Extended right arrives on the same edge as a frame: that frame uses old state.
    send(8'hE0);
    expect_ev(8'h74, 1'b1, 1'b0); send_with_frame(8'h74);
    check("ext_right_held", 32'(key_held), 32'b1000);
    check_pos("same_edge", 10'd100, 10'd188);
    frame(); check_pos("right_f1", 10'd104, 10'd188);
    expect_ev(8'h74, 1'b1, 1'b1); send(8'hE0); send(8'hF0); send(8'h74);
    @(negedge clk); check("ext_right_released", 32'(key_held), 32'b0000);
    frame(); check_pos("right_frozen", 10'd104, 10'd188);

    // Opposing left+right cancel.
    expect_ev(8'h1C, 1'b0, 1'b0); send(8'h1C);
    expect_ev(8'h23, 1'b0, 1'b0); send(8'h23);
    @(negedge clk); check("opposing_held", 32'(key_held), 32'b1100);
    frame(); check_pos("opp_f1", 10'd104, 10'd188);
    frame(); check_pos("opp_f2", 10'd104, 10'd188);
    expect_ev(8'h1C, 1'b0, 1'b1); send(8'hF0); send(8'h1C);
    expect_ev(8'h23, 1'b0, 1'b1); send(8'hF0); send(8'h23);
    @(negedge clk); check("opposing_released", 32'(key_held), 32'b0000);

    // Unmapped make, and E0 after F0 is ignored (plain break).
    expect_ev(8'h5A, 1'b0, 1'b0); send(8'h5A);
    expect_ev(8'h5A, 1'b0, 1'b1); send(8'hF0); send(8'hE0); send(8'h5A);
    @(negedge clk); check("unmapped_no_key", 32'(key_held), 32'b0000);

    // Clamping on the corner instance: right+up held.
    send(8'h23, 1'b1); send(8'h1D, 1'b1);
    @(negedge clk); check("clamp_held", 32'(key_held_c), 32'b1001);
    frame();
    check("clamp_x_f1", 32'(x_pos_c), 32'd590);
    check("clamp_y_f1", 32'(y_pos_c), 32'd0);
    frame();
    check("clamp_x_f2", 32'(x_pos_c), 32'd590);
    check("clamp_y_f2", 32'(y_pos_c), 32'd0);
    check_pos("main_unmoved", 10'd104, 10'd188);

    // Reset between E0 and 75 discards the prefix.
    send(8'hE0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("midrst_x", 32'(x_pos), 32'd100);
    check("midrst_y", 32'(y_pos), 32'd200);
    check("midrst_corner_x", 32'(x_pos_c), 32'd588);
    reset = 1'b1;
    expect_ev(8'h75, 1'b0, 1'b0); send(8'h75);
    @(negedge clk); check("after_rst_key_held", 32'(key_held), 32'b0000);

    repeat (4) @(negedge clk);
    check("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
